// File: rtl/mipi_lane_merge_ctrl.sv
// Two-lane MIPI byte merger: per-lane 4-deep FIFOs, lane skew alignment, {lane1,lane0} word output.
// Define MERGE_WORD_CNT_EN to add the per-packet word_cnt output.
module mipi_lane_merge_ctrl #(
    parameter int unsigned SKEW_MAX = 3,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        lane0_hs,
    input  logic        lane1_hs,
    input  logic        lane0_byte_en,
    input  logic        lane1_byte_en,
    input  logic [7:0]  lane0_byte,
    input  logic [7:0]  lane1_byte,
    output logic        word_en,
    output logic [15:0] word,
    output logic        pkt_active,
    output logic        skew_err,
`ifdef MERGE_WORD_CNT_EN
    output logic        sync_err,
    output logic [15:0] word_cnt
`else
    output logic        sync_err
`endif
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALIGN  = 2'd1,
        STREAM = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam logic [2:0] SKEW_LIM = 3'(SKEW_MAX);
    localparam logic [7:0] TMO_LIM  = 8'(TIMEOUT);

    state_t     state, state_nx;
    logic [1:0] hs, push, wr, nempty, full;
    logic [7:0] din [2];
    logic [7:0] mem [2][4];
    logic [1:0] wp  [2];
    logic [1:0] rp  [2];
    logic [2:0] cnt [2];
    logic [2:0] skew_cnt;
    logic [7:0] tmo, tmo_nx;
    logic       pop, pop_ok, flush, ovf, mismatch, tmo_hit, skew_hit, sync_hit;

    assign hs      = {lane1_hs, lane0_hs};
    assign din[0]  = lane0_byte;
    assign din[1]  = lane1_byte;
    assign push[0] = lane0_byte_en & lane0_hs & (state != ERR);
    assign push[1] = lane1_byte_en & lane1_hs & (state != ERR);
    assign nempty  = {cnt[1] != 3'd0, cnt[0] != 3'd0};
    assign full    = {cnt[1] == 3'd4, cnt[0] == 3'd4};

    assign pop      = (state == STREAM) & (&nempty);
    assign ovf      = (|(push & full)) & ~pop;
    assign mismatch = (hs == 2'b00) & (nempty[0] ^ nempty[1]);
    assign tmo_nx   = pop ? 8'd0 : (((|hs) && tmo != 8'hFF) ? tmo + 8'd1 : tmo);
    assign tmo_hit  = ~pop & (|hs) & (tmo_nx == TMO_LIM);

    // A pending pop and any push are dropped on the edge that enters ERR.
    assign flush  = (state_nx == ERR) & (state != ERR);
    assign pop_ok = pop & ~flush;
    assign wr     = push & (~full | {2{pop}}) & {2{~flush}};

    assign pkt_active = (state == ALIGN) | (state == STREAM);

    always_comb begin
        state_nx = state;
        skew_hit = 1'b0;
        sync_hit = 1'b0;
        case (state)
            IDLE: begin
                if (&push)      state_nx = STREAM;
                else if (|push) state_nx = ALIGN;
            end
            ALIGN: begin
                if (&nempty) begin
                    state_nx = STREAM;
                end else if (skew_cnt > SKEW_LIM) begin
                    state_nx = ERR;
                    skew_hit = 1'b1;
                end
            end
            STREAM: begin
                if (ovf | mismatch | tmo_hit) begin
                    state_nx = ERR;
                    sync_hit = 1'b1;
                end else if (hs == 2'b00 && nempty == 2'b00) begin
                    state_nx = IDLE;
                end
            end
            ERR: begin
                if (hs == 2'b00) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            skew_cnt <= '0;
            tmo      <= '0;
            word_en  <= 1'b0;
            word     <= '0;
            skew_err <= 1'b0;
            sync_err <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                wp[i]  <= '0;
                rp[i]  <= '0;
                cnt[i] <= '0;
            end
        end else begin
            state    <= state_nx;
            skew_cnt <= (state != ALIGN) ? 3'd0 :
                        ((skew_cnt == 3'd7) ? skew_cnt : skew_cnt + 3'd1);
            tmo      <= (state == STREAM) ? tmo_nx : 8'd0;
            word_en  <= pop_ok;
            skew_err <= skew_hit;
            sync_err <= sync_hit;
            if (pop_ok) word <= {mem[1][rp[1]], mem[0][rp[0]]};
            for (int unsigned i = 0; i < 2; i++) begin
                if (flush) begin
                    wp[i]  <= '0;
                    rp[i]  <= '0;
                    cnt[i] <= '0;
                end else begin
                    if (wr[i])  wp[i] <= wp[i] + 2'd1;
                    if (pop_ok) rp[i] <= rp[i] + 2'd1;
                    cnt[i] <= cnt[i] + {2'b00, wr[i]} - {2'b00, pop_ok};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 2; i++) begin
            if (wr[i]) mem[i][wp[i]] <= din[i];
        end
    end

`ifdef MERGE_WORD_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                    word_cnt <= '0;
        else if (state_nx == IDLE && state != IDLE)   word_cnt <= '0;
        else if (pop_ok && word_cnt != 16'hFFFF)      word_cnt <= word_cnt + 16'd1;
    end
`endif

endmodule
